// File: rtl/pll_cfg_ctrl_if.sv
// Request/response handshake bundle for the PLL configuration sequencer.
// Signal names keep their pin-level suffixes so waveforms map 1:1 to the block pins.
interface pll_cfg_ctrl_if #(
  parameter int REF_DEV_WIDTH = 4,
  parameter int FB_DIV_WIDTH  = 8
);
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [REF_DEV_WIDTH-1:0] req_refdiv_i;
  logic [FB_DIV_WIDTH-1:0]  req_fbdiv_i;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [1:0]               rsp_status_o;

  modport master (
    output req_valid_i, req_refdiv_i, req_fbdiv_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_status_o
  );

  modport slave (
    input  req_valid_i, req_refdiv_i, req_fbdiv_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_status_o
  );
endinterface

// File: rtl/pll_cfg_ctrl.sv
// PLL configuration and lock sequencer: validates divider requests, pulses the
// PLL reset, qualifies lock with a stability window, timeout and bounded retries,
// and re-acquires lock on its own if the PLL drops out while in service.
module pll_cfg_ctrl #(
  parameter int REF_DEV_WIDTH = 4,
  parameter int FB_DIV_WIDTH  = 8,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_STABLE   = 8,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int MAX_RETRY     = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  pll_cfg_ctrl_if.slave            bus,
  output logic                     pll_arst_no,
  output logic [REF_DEV_WIDTH-1:0] pll_refdiv_o,
  output logic [FB_DIV_WIDTH-1:0]  pll_fbdiv_o,
  input  logic                     pll_locked_i,
  output logic                     locked_o,
  output logic                     busy_o,
  output logic                     lock_lost_o
);
  typedef enum logic [1:0] {IDLE, RESET_HOLD, WAIT_LOCK, LOCKED} state_t;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_BAD = 2'd1;
  localparam logic [1:0] ST_TMO = 2'd2;

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int TCW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SCW = $clog2(LOCK_STABLE + 1);
  localparam int RYW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(LOCK_TIMEOUT - 1);
  localparam logic [TCW-1:0] TC_MAX  = TCW'(LOCK_TIMEOUT);
  localparam logic [SCW-1:0] SC_LAST = SCW'(LOCK_STABLE - 1);
  localparam logic [SCW-1:0] SC_MAX  = SCW'(LOCK_STABLE);
  localparam logic [RYW-1:0] RY_MAX  = RYW'(MAX_RETRY);

  state_t                   r_state;
  logic                     r_lk_s1, r_lk_s;
  logic [RCW-1:0]           r_rst_cnt;
  logic [TCW-1:0]           r_to_cnt;
  logic [SCW-1:0]           r_stab_cnt;
  logic [RYW-1:0]           r_retry;
  logic                     r_from_req;
  logic                     r_arst_n;
  logic [REF_DEV_WIDTH-1:0] r_refdiv;
  logic [FB_DIV_WIDTH-1:0]  r_fbdiv;
  logic                     r_locked;
  logic                     r_lock_lost;
  logic                     r_rsp_valid;
  logic [1:0]               r_rsp_status;

  logic w_ready, w_accept, w_bad;

  // Requests are only taken when no sequence is running and no response is owed.
  assign w_ready  = ~rst_i & ((r_state == IDLE) | (r_state == LOCKED)) & ~r_rsp_valid;
  assign w_accept = bus.req_valid_i & w_ready;
  assign w_bad    = (bus.req_refdiv_i == '0) | (bus.req_fbdiv_i == '0);

  assign bus.req_ready_o  = w_ready;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_status_o = r_rsp_status;
  assign pll_arst_no      = r_arst_n;
  assign pll_refdiv_o     = r_refdiv;
  assign pll_fbdiv_o      = r_fbdiv;
  assign locked_o         = r_locked;
  assign lock_lost_o      = r_lock_lost;
  assign busy_o           = (r_state == RESET_HOLD) | (r_state == WAIT_LOCK);

  // Two-flop synchronizer for the asynchronous raw lock indication.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lk_s1 <= 1'b0;
      r_lk_s  <= 1'b0;
    end else begin
      r_lk_s1 <= pll_locked_i;
      r_lk_s  <= r_lk_s1;
    end
  end

  // Sequencer FSM with its counters, PLL-side outputs and the response register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_rst_cnt    <= '0;
      r_to_cnt     <= '0;
      r_stab_cnt   <= '0;
      r_retry      <= '0;
      r_from_req   <= 1'b0;
      r_arst_n     <= 1'b0;
      r_refdiv     <= '0;
      r_fbdiv      <= '0;
      r_locked     <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= ST_OK;
    end else begin
      r_lock_lost <= 1'b0;
      if (r_rsp_valid && bus.rsp_ready_i) r_rsp_valid <= 1'b0;

      case (r_state)
        IDLE, LOCKED: begin
          if (w_accept && !w_bad) begin
            // A new request pre-empts a coincident lock loss, which is still flagged.
            r_refdiv   <= bus.req_refdiv_i;
            r_fbdiv    <= bus.req_fbdiv_i;
            r_retry    <= '0;
            r_rst_cnt  <= '0;
            r_arst_n   <= 1'b0;
            r_locked   <= 1'b0;
            r_from_req <= 1'b1;
            r_state    <= RESET_HOLD;
            if (r_state == LOCKED && !r_lk_s) r_lock_lost <= 1'b1;
          end else begin
            if (w_accept) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= ST_BAD;
            end
            // Autonomous relock: no PLL reset and nobody to answer.
            if (r_state == LOCKED && !r_lk_s) begin
              r_lock_lost <= 1'b1;
              r_locked    <= 1'b0;
              r_retry     <= '0;
              r_to_cnt    <= '0;
              r_stab_cnt  <= '0;
              r_from_req  <= 1'b0;
              r_state     <= WAIT_LOCK;
            end
          end
        end

        RESET_HOLD: begin
          r_to_cnt   <= '0;
          r_stab_cnt <= '0;
          if (r_rst_cnt == RC_LAST) begin
            r_arst_n <= 1'b1;
            r_state  <= WAIT_LOCK;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (!r_lk_s)                 r_stab_cnt <= '0;
          else if (r_stab_cnt != SC_MAX) r_stab_cnt <= r_stab_cnt + 1'b1;
          if (r_to_cnt != TC_MAX)      r_to_cnt   <= r_to_cnt + 1'b1;

          // Lock qualification wins over a timeout landing on the same cycle.
          if (r_lk_s && r_stab_cnt == SC_LAST) begin
            r_locked   <= 1'b1;
            r_state    <= LOCKED;
            r_from_req <= 1'b0;
            if (r_from_req) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= ST_OK;
            end
          end else if (r_to_cnt == TC_LAST) begin
            r_arst_n <= 1'b0;
            if (r_retry != RY_MAX) begin
              r_retry   <= r_retry + 1'b1;
              r_rst_cnt <= '0;
              r_state   <= RESET_HOLD;
            end else begin
              r_state    <= IDLE;
              r_from_req <= 1'b0;
              if (r_from_req) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_status <= ST_TMO;
              end
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pll_cfg_ctrl.md
# pll_cfg_ctrl

Configuration and lock sequencer for the on-chip `pll`. It runs on an always-on system clock, takes divider-change requests over a valid/ready handshake, and checks them. It then holds the PLL in reset, applies the new `refdiv`/`fbdiv`, releases reset and qualifies lock with a timeout and bounded retries. It returns one status response per request and autonomously re-acquires lock if the PLL drops it while in service.

## Interface
- `REF_DEV_WIDTH`, 4, width of reference divider
- `FB_DIV_WIDTH`, 8, width of feedback divider
- `RST_CYCLES`, 16, cycles PLL reset is held low per attempt (>=1)
- `LOCK_STABLE`, 8, consecutive synchronized-lock cycles needed to declare lock (>=1)
- `LOCK_TIMEOUT`, 4096, cycles allowed per attempt after reset release
- `MAX_RETRY`, 3, extra attempts after the first before failing (>=0)
- `clk_i` in 1: system clock; single clock domain
- `rst_i` in 1: reset, synchronous, active-high
- `req_valid_i` in 1: request valid
- `req_ready_o` out 1: request accepted when valid&ready
- `req_refdiv_i` in REF_DEV_WIDTH: requested reference divider
- `req_fbdiv_i` in FB_DIV_WIDTH: requested feedback divider
- `rsp_valid_o` out 1: response valid; held until `rsp_ready_i`
- `rsp_ready_i` in 1: response consumed
- `rsp_status_o` out 2: 0=OK, 1=BAD_CFG, 2=TIMEOUT
- `pll_arst_no` out 1: PLL reset, active-low, registered
- `pll_refdiv_o` out REF_DEV_WIDTH: registered reference divider to PLL
- `pll_fbdiv_o` out FB_DIV_WIDTH: registered feedback divider to PLL
- `pll_locked_i` in 1: raw PLL lock (asynchronous to clk_i)
- `locked_o` out 1: qualified lock
- `busy_o` out 1: sequence in progress (RESET_HOLD or WAIT_LOCK)
- `lock_lost_o` out 1: one-cycle pulse on loss of qualified lock

## Operation
- `pll_locked_i` passes through a 2-flop synchronizer (`lk_s`) before any use.
- States: IDLE, RESET_HOLD, WAIT_LOCK, LOCKED.
- `req_ready_o` = (state is IDLE or LOCKED) and not `rsp_valid_o`.
- Accept with `refdiv==0` or `fbdiv==0`:
  - Response BAD_CFG.
  - State, PLL outputs and `locked_o` are unchanged.
- Accept with a valid config:
  - Latch the dividers into `pll_*div_o`, clear the retry count, go to RESET_HOLD.
  - `locked_o` drops.
- RESET_HOLD:
  - `pll_arst_no`=0 for RST_CYCLES cycles, then go to WAIT_LOCK with `pll_arst_no`=1.
  - The timeout and stable counters clear.
- WAIT_LOCK:
  - The stable counter increments while `lk_s`=1 and clears when `lk_s`=0.
  - When it reaches LOCK_STABLE, go to LOCKED with `locked_o`=1. Respond OK if this sequence came from a request.
  - When the timeout counter reaches LOCK_TIMEOUT first:
    - If retry < MAX_RETRY: retry++, go to RESET_HOLD.
    - Otherwise: go to IDLE with `pll_arst_no`=0. Respond TIMEOUT if request-originated.
- LOCKED: if `lk_s`=0, pulse `lock_lost_o`, clear `locked_o`, clear retry, and go to WAIT_LOCK (autonomous, no reset first, no response generated).
- Simultaneous loss of lock and an accepted valid request in LOCKED: the request wins (go to RESET_HOLD, request-originated). `lock_lost_o` still pulses.
- Response register: set `rsp_valid_o` with status, clear on `rsp_valid_o & rsp_ready_i`. The FSM proceeds independently of response consumption.
- Counters are sized `$clog2(param+1)` and saturate, never wrap.

## Timing
- Reset values:
  - `req_ready_o`=0 during reset and 1 on the first cycle after.
  - `rsp_valid_o`=0, `rsp_status_o`=0.
  - `pll_arst_no`=0, `pll_refdiv_o`=0, `pll_fbdiv_o`=0.
  - `locked_o`=0, `busy_o`=0, `lock_lost_o`=0, state IDLE.
- Accept in cycle N:
  - BAD_CFG: `rsp_valid_o`=1 at N+1.
  - Valid config: new dividers and `pll_arst_no`=0 at N+1, `pll_arst_no`=1 at N+1+RST_CYCLES.
- Lock latency: `pll_locked_i` rising at cycle M (after release) gives `locked_o`=1 and OK response at M+2+LOCK_STABLE.
- Full failure: request to TIMEOUT response takes (MAX_RETRY+1)×(RST_CYCLES+LOCK_TIMEOUT)+1 cycles.
- Loss of lock: `lk_s` falling at cycle L gives `lock_lost_o` and `locked_o`=0 at L+1.
- `rst_i` mid-sequence: everything returns to reset values next cycle. A pending response is discarded.

## Test plan
- Reset, then request refdiv=2, fbdiv=40, with the lock model asserting 100 cycles after release:
  - `pll_arst_no` low for exactly 16 cycles.
  - OK response 100+2+8 cycles after release; `locked_o`=1.
- Request fbdiv=0 from LOCKED: BAD_CFG at N+1; dividers, `pll_arst_no` and `locked_o` unchanged.
- Lock never asserts (MAX_RETRY=3): 4 reset pulses, then TIMEOUT response; final state IDLE with `pll_arst_no`=0.
- Lock glitches low for 3 cycles during WAIT_LOCK:
  - The stable counter restarts.
  - Lock is declared only after 8 uninterrupted high cycles.
- In LOCKED, drop `pll_locked_i` for 20 cycles:
  - `lock_lost_o` pulses once; no response is generated.
  - Relock sets `locked_o`=1 with no PLL reset pulse.
- Hold `rsp_ready_i`=0 after an OK response:
  - `req_ready_o` stays 0 and the response holds.
  - Raising `rsp_ready_i` clears the response, and `req_ready_o`=1 next cycle.
